// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared datapath widths and the fetch entry type
package datapath_pkg;

  localparam int WORD_W = 32;

  // One queued fetch: the instruction word and the PC it came from.
  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } fetch_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue between fetch unit and dispatch (optional FETCH_QUEUE_BYPASS_EN empty-queue bypass)
module fetch_queue
  import datapath_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     imem_valid,
  input  logic [WORD_W-1:0]        imem_instr,
  input  logic [WORD_W-1:0]        imem_pc,
  output logic                     imem_ready,
  output logic                     fetch_valid,
  output logic [WORD_W-1:0]        fetch_instr,
  output logic [WORD_W-1:0]        fetch_pc,
  input  logic                     dispatch_ready,
  input  logic                     branch_miss,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fetch_t          mem [DEPTH];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            full;
  logic            empty;
  logic            do_enq;
  logic            do_deq;
  logic            bypass;
  fetch_t          head;

  // Occupancy flags from registered pointers only; the wrap bit separates full from empty.
  always_comb begin
    empty = (wptr == rptr);
    full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
    count = wptr - rptr;
    head  = mem[rptr[AW-1:0]];
  end

`ifdef FETCH_QUEUE_BYPASS_EN
  // Empty queue forwards the incoming word straight to dispatch; if dispatch takes it, it is never stored.
  always_comb begin
    bypass      = empty && imem_valid && !branch_miss;
    imem_ready  = !full && !branch_miss;
    fetch_valid = (!empty || imem_valid) && !branch_miss;
    fetch_instr = bypass ? imem_instr : head.instr;
    fetch_pc    = bypass ? imem_pc    : head.pc;
    do_enq      = imem_valid && imem_ready && !(bypass && dispatch_ready);
    do_deq      = !empty && !branch_miss && dispatch_ready;
  end
`else
  // Registered-only output path: a written entry becomes visible the cycle after the write edge.
  always_comb begin
    bypass      = 1'b0;
    imem_ready  = !full && !branch_miss;
    fetch_valid = !empty && !branch_miss;
    fetch_instr = head.instr;
    fetch_pc    = head.pc;
    do_enq      = imem_valid && imem_ready;
    do_deq      = fetch_valid && dispatch_ready;
  end
`endif

  // Pointer update; a branch miss empties the queue and wins over any enqueue/dequeue.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wptr <= '0;
      rptr <= '0;
    end else if (branch_miss) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_enq) wptr <= wptr + 1'b1;
      if (do_deq) rptr <= rptr + 1'b1;
    end
  end

  // Entry storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_enq) begin
      mem[wptr[AW-1:0]] <= '{instr: imem_instr, pc: imem_pc};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;
  import datapath_pkg::*;

  logic              CLK;
  logic              nRST;
  logic              imem_valid;
  logic [31:0]       imem_instr;
  logic [31:0]       imem_pc;
  logic              imem_ready;
  logic              fetch_valid;
  logic [31:0]       fetch_instr;
  logic [31:0]       fetch_pc;
  logic              dispatch_ready;
  logic              branch_miss;
  logic [2:0]        count;

  int checks = 0;
  int errors = 0;

  fetch_queue #(.DEPTH(4)) dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .imem_valid     (imem_valid),
    .imem_instr     (imem_instr),
    .imem_pc        (imem_pc),
    .imem_ready     (imem_ready),
    .fetch_valid    (fetch_valid),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .dispatch_ready (dispatch_ready),
    .branch_miss    (branch_miss),
    .count          (count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    imem_valid     = 1'b0;
    imem_instr     = '0;
    imem_pc        = '0;
    dispatch_ready = 1'b0;
    branch_miss    = 1'b0;
  endtask

  initial begin
    int enq_n;
    int deq_n;
    int cyc;

    idle();
    nRST = 1'b0;
    #3;
    check("rst_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_fetch_instr", fetch_instr, 32'd0);
    check("rst_fetch_pc",    fetch_pc,    32'd0);
    check("rst_imem_ready",  {31'd0, imem_ready}, 32'd1);
    check("rst_count",       {29'd0, count}, 32'd0);
    #14;
    nRST = 1'b1;
    step();

    // Single enqueue, visible the next cycle
    imem_valid = 1'b1; imem_instr = 32'h0000_0013; imem_pc = 32'h100;
`ifndef FETCH_QUEUE_BYPASS_EN
    #1;
    check("enq_not_yet_visible", {31'd0, fetch_valid}, 32'd0);
`endif
    step();
    imem_valid = 1'b0;
    #1;
    check("enq1_fetch_valid", {31'd0, fetch_valid}, 32'd1);
    check("enq1_fetch_instr", fetch_instr, 32'h0000_0013);
    check("enq1_fetch_pc",    fetch_pc,    32'h100);
    check("enq1_count",       {29'd0, count}, 32'd1);

    // Flush back to empty
    branch_miss = 1'b1;
    step();
    branch_miss = 1'b0;
    #1;
    check("flush_count", {29'd0, count}, 32'd0);
    check("flush_valid", {31'd0, fetch_valid}, 32'd0);

    // Fill: five offered, four accepted
    for (int i = 0; i < 5; i++) begin
      imem_valid = 1'b1;
      imem_instr = 32'hA000_0000 + i;
      imem_pc    = 32'h1000 + 4 * i;
      #1;
      check($sformatf("fill_ready_%0d", i), {31'd0, imem_ready}, (i < 4) ? 32'd1 : 32'd0);
      step();
    end
    imem_valid = 1'b0;
    #1;
    check("full_count",      {29'd0, count}, 32'd4);
    check("full_imem_ready", {31'd0, imem_ready}, 32'd0);
    check("full_head_pc",    fetch_pc, 32'h1000);

    // Full queue with enqueue and dequeue offered: only the dequeue happens
    imem_valid = 1'b1; imem_instr = 32'h9999_9999; imem_pc = 32'h9999;
    dispatch_ready = 1'b1;
    #1;
    check("fullrw_ready", {31'd0, imem_ready}, 32'd0);
    step();
    imem_valid = 1'b0; dispatch_ready = 1'b0;
    #1;
    check("fullrw_count",   {29'd0, count}, 32'd3);
    check("fullrw_head_pc", fetch_pc, 32'h1004);

    // Drain remaining entries in order; rejected words never appear
    dispatch_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      #1;
      check($sformatf("drain_pc_%0d", k), fetch_pc, 32'h1000 + 4 * k);
      check($sformatf("drain_instr_%0d", k), fetch_instr, 32'hA000_0000 + k);
      step();
    end
    dispatch_ready = 1'b0;
    #1;
    check("drained_count", {29'd0, count}, 32'd0);
    check("drained_valid", {31'd0, fetch_valid}, 32'd0);

    // Stream 10 words across pointer wrap with toggling dispatch_ready
    enq_n = 0; deq_n = 0; cyc = 0;
    while (deq_n < 10 && cyc < 200) begin
      imem_valid     = (enq_n < 10);
      imem_pc        = 32'h4 * enq_n;
      imem_instr     = 32'hABCD_0000 ^ (32'h4 * enq_n);
      dispatch_ready = cyc[0];
      #1;
      check("stream_count", {29'd0, count}, enq_n - deq_n);
      if (fetch_valid && dispatch_ready) begin
        check("stream_pc",    fetch_pc,    32'h4 * deq_n);
        check("stream_instr", fetch_instr, 32'hABCD_0000 ^ (32'h4 * deq_n));
        deq_n++;
      end
      if (imem_valid && imem_ready) enq_n++;
      step();
      cyc++;
    end
    check("stream_done", deq_n, 32'd10);
    idle();

    // Branch miss drops queued and incoming words
    for (int i = 0; i < 3; i++) begin
      imem_valid = 1'b1; imem_pc = 32'h300 + 4 * i; imem_instr = 32'h300 + i;
      step();
    end
    imem_valid = 1'b0;
    #1;
    check("bm_pre_count", {29'd0, count}, 32'd3);
    branch_miss = 1'b1; imem_valid = 1'b1; imem_pc = 32'hDEAD; imem_instr = 32'hDEAD;
    dispatch_ready = 1'b1;
    #1;
    check("bm_fetch_valid", {31'd0, fetch_valid}, 32'd0);
    check("bm_imem_ready",  {31'd0, imem_ready}, 32'd0);
    step();
    idle();
    #1;
    check("bm_post_count", {29'd0, count}, 32'd0);
    check("bm_post_valid", {31'd0, fetch_valid}, 32'd0);
    imem_valid = 1'b1; imem_pc = 32'h400; imem_instr = 32'h400;
    step();
    imem_valid = 1'b0;
    #1;
    check("bm_next_head", fetch_pc, 32'h400);
    check("bm_next_count", {29'd0, count}, 32'd1);

    // Asynchronous reset mid-operation
    imem_valid = 1'b1; imem_pc = 32'h404; imem_instr = 32'h404;
    step();
    imem_valid = 1'b0;
    nRST = 1'b0;
    #1;
    check("arst_count", {29'd0, count}, 32'd0);
    check("arst_valid", {31'd0, fetch_valid}, 32'd0);
    check("arst_pc",    fetch_pc, 32'd0);
    #2;
    nRST = 1'b1;
    step();
    imem_valid = 1'b1; imem_pc = 32'h500; imem_instr = 32'h500;
    step();
    imem_valid = 1'b0;
    #1;
    check("arst_first_head", fetch_pc, 32'h500);
    check("arst_first_count", {29'd0, count}, 32'd1);

`ifdef FETCH_QUEUE_BYPASS_EN
    dispatch_ready = 1'b1;
    step();
    dispatch_ready = 1'b0;
    #1;
    check("byp_pre_count", {29'd0, count}, 32'd0);
    imem_valid = 1'b1; imem_pc = 32'h200; imem_instr = 32'h200; dispatch_ready = 1'b1;
    #1;
    check("byp_valid", {31'd0, fetch_valid}, 32'd1);
    check("byp_pc",    fetch_pc, 32'h200);
    step();
    idle();
    #1;
    check("byp_count", {29'd0, count}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
- REQ-001 The block SHALL have parameter DEPTH, default 4, number of queue entries; a power of two, minimum 2.
- REQ-002 The block SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
- REQ-003 The block SHALL have port nRST, input, 1, asynchronous active-low reset.
- REQ-004 The block SHALL have port imem_valid, input, 1, fetch unit presents an instruction this cycle.
- REQ-005 The block SHALL have port imem_instr, input, 32, fetched instruction word.
- REQ-006 The block SHALL have port imem_pc, input, 32, PC of imem_instr.
- REQ-007 The block SHALL have port imem_ready, output, 1, queue accepts an enqueue this cycle.
- REQ-008 The block SHALL have port fetch_valid, output, 1, head entry is valid for the scoreboard dispatch stage.
- REQ-009 The block SHALL have port fetch_instr, output, 32, head instruction.
- REQ-010 The block SHALL have port fetch_pc, output, 32, head PC.
- REQ-011 The block SHALL have port dispatch_ready, input, 1, dispatch consumes the head this cycle when fetch_valid is high.
- REQ-012 The block SHALL have port branch_miss, input, 1, flush request from branch resolution.
- REQ-013 The block SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.

Function
- REQ-014 The block SHALL be a circular FIFO with read/write pointers of $clog2(DEPTH)+1 bits; the extra MSB is the wrap bit; full = index bits equal and MSBs differ; empty = pointers equal.
- REQ-015 Enqueue SHALL occur when imem_valid && imem_ready; dequeue SHALL occur when fetch_valid && dispatch_ready.
- REQ-016 imem_ready SHALL be !full && !branch_miss, registered-state based: a full queue rejects an enqueue even when a dequeue occurs in the same cycle.
- REQ-017 fetch_valid SHALL be !empty && !branch_miss; fetch_instr/fetch_pc SHALL be the head entry.
- REQ-018 Enqueue-to-fetch_valid latency SHALL be 1 cycle (entry visible the cycle after the write edge).
- REQ-019 Simultaneous enqueue and dequeue on a non-full, non-empty queue SHALL leave count unchanged and advance both pointers.
- REQ-020 Pointers SHALL wrap modulo 2*DEPTH; the entry order SHALL be preserved across wrap-around.
- REQ-021 branch_miss SHALL reset both pointers and count to 0 at the next edge, overriding any enqueue or dequeue that cycle; the imem input that cycle SHALL be dropped.
- REQ-022 count SHALL equal wptr - rptr (modulo 2*DEPTH), range 0..DEPTH.

Reset
- REQ-023 On nRST low, asynchronously: pointers 0, count 0, all storage 0; hence fetch_valid 0, fetch_instr 0, fetch_pc 0, imem_ready 1.
- REQ-024 Reset asserted mid-operation SHALL discard all entries; the first enqueue after release SHALL appear as head.

Configuration
- REQ-025 With FETCH_QUEUE_BYPASS_EN defined: when empty and imem_valid && !branch_miss, fetch_valid SHALL be 1 in the same cycle with imem_instr/imem_pc passed through; if dispatch_ready is also 1, the entry SHALL NOT be written and count stays 0.
- REQ-026 Without FETCH_QUEUE_BYPASS_EN: no combinational path from imem_* to fetch_*; REQ-018 latency holds.

Structure
- REQ-027 datapath_pkg SHALL hold WORD_W = 32 and the typedef fetch_t {instr, pc}; storage SHALL be an array of fetch_t.
- REQ-028 No sub-module is needed; pointer, storage and bypass logic SHALL live in fetch_queue (~150 lines).

Verification
- REQ-029 Reset, then enqueue 0x00000013 @ pc 0x100 with dispatch_ready=0 -> next cycle fetch_valid=1, fetch_instr=0x00000013, fetch_pc=0x100, count=1.
- REQ-030 DEPTH=4, dispatch_ready=0, enqueue 5 words -> imem_ready=0 after the 4th; the 5th is not stored; count=4.
- REQ-031 Full queue, imem_valid=1, dispatch_ready=1 for one cycle -> one dequeue, no enqueue, count=3.
- REQ-032 Stream 10 words pc 0x0..0x24 with dispatch_ready toggling -> dequeued PCs are strictly 0x0,0x4,...,0x24 across the pointer wrap.
- REQ-033 count=3, branch_miss=1 together with imem_valid=1 and dispatch_ready=1 -> fetch_valid=0 that cycle, count=0 next cycle, dropped word never appears.
- REQ-034 With FETCH_QUEUE_BYPASS_EN, empty queue, imem_valid=1 pc 0x200, dispatch_ready=1 -> fetch_valid=1, fetch_pc=0x200 same cycle, count stays 0.
